u_wb: RTL and testbench
=======================

Name: u_wb

Overview:
Writeback unit that drives the register file write port (rd_e/rd_a/rd_i). It merges two result sources and writes them back in a fixed priority order. The first source is single-cycle ALU results under a valid/ready handshake. The second is in-order memory load responses, which are tracked by a small pending-load queue and then byte/half-selected and sign/zero-extended. It also keeps a load scoreboard, so decode can stall on registers that are waiting for load data.

Parameters:
XLEN, 32, datapath width
LQ_DEPTH, 4, pending-load queue entries (power of two, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
alu_v  input  1  ALU result valid
alu_rdy  output  1  ALU result accepted this cycle when alu_v & alu_rdy
alu_rd_a  input  5  ALU destination register
alu_rd_i  input  XLEN  ALU result
ld_issue_v  input  1  load issued to memory
ld_issue_rdy  output  1  load queue can accept
ld_issue_rd_a  input  5  load destination register
ld_issue_f3  input  3  load funct3
ld_issue_off  input  2  byte offset addr[1:0]
ld_rsp_v  input  1  memory load data valid (in order, no backpressure)
ld_rsp_data  input  XLEN  raw aligned word from memory
rs1_a  input  5  decode source 1 address
rs2_a  input  5  decode source 2 address
hazard_o  output  1  a source register has a pending load
busy_o  output  32  per-register pending-load mask
rd_e  output  1  regfile write enable
rd_a  output  5  regfile write address
rd_i  output  XLEN  regfile write data
err_o  output  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - Load queue is emptied.
  - rd_e=0, rd_a=0, rd_i=0, err_o=0.
  - ld_issue_rdy=1 and alu_rdy=1 immediately after reset deasserts.
- Load queue:
  - FIFO of {rd_a, f3, off}, with count 0..LQ_DEPTH.
  - ld_issue_rdy = (count < LQ_DEPTH). It depends only on count, so a response popping in the same cycle does not free a slot for a same-cycle issue.
  - Issue and response in the same cycle: push and pop both happen and count is unchanged.
  - Pointers wrap modulo LQ_DEPTH.
- ld_rsp_v while the queue is empty:
  - The response is dropped and nothing is written.
  - err_o is set and stays set until reset.
- Arbitration and write priority:
  - alu_rdy = ~ld_rsp_v. A load response always wins. The ALU must hold alu_v and its data until accepted.
- Write latency:
  - An event accepted in cycle N produces rd_e/rd_a/rd_i registered in cycle N+1.
  - If nothing is accepted in cycle N, rd_e=0 in N+1. rd_a and rd_i hold their previous values.
- Register 0:
  - Any accepted write with destination 0 gives rd_e=0 in N+1.
  - A load to x0 still pops its queue entry.
- Load data formatting (off selects the byte or half; off[0] is ignored for half-word loads):
  - f3=000 LB: sign-extend byte[off].
  - f3=100 LBU: zero-extend byte[off].
  - f3=001 LH: sign-extend half[off[1]].
  - f3=101 LHU: zero-extend half[off[1]].
  - f3=010 LW: full word.
  - Any other f3: rd_i=0, rd_e still follows the rd_a!=0 rule, and err_o is set.
- Scoreboard:
  - busy_o[r]=1 when any valid queue entry has rd_a==r, for r!=0. busy_o[0] is always 0.
  - busy_o is combinational over the queue. Its bit drops in the cycle after the pop (N+1), which is the cycle the regfile forwards rd_i.
  - hazard_o = busy_o[rs1_a] | busy_o[rs2_a].
- Write-after-write hazards are upstream's responsibility: upstream must not issue an ALU or load write to a register whose busy_o bit is set. u_wb does not reorder writes.
- A reset during pending loads flushes the queue. Any response that arrives after reset sets err_o.

Test Plan:
- ALU write, idle queue: alu_v=1, alu_rd_a=5, alu_rd_i=0x1234 at cycle N -> rd_e=1, rd_a=5, rd_i=0x1234 at N+1; rd_e=0 at N+2.
- Load formatting: issue rd_a=7, f3=000, off=3, then respond with 0x80FF_0000 -> rd_i=0xFFFF_FF80. Same word with f3=100 -> 0x0000_0080. f3=001, off=2 -> 0xFFFF_80FF. f3=010 -> 0x80FF_0000.
- Collision: ld_rsp_v and alu_v in the same cycle -> alu_rdy=0 and the load is written first. The ALU value (held) is written on the following cycle.
- Queue full: issue 4 loads (rd 1..4) -> ld_issue_rdy=0 and busy_o=0x1E. A 5th issue is not accepted. One response -> rd_a=1 written, busy_o=0x1C, ld_issue_rdy returns to 1.
- x0 and errors:
  - Load issued with rd_a=0 -> busy_o stays 0, and its response gives rd_e=0 and pops the entry.
  - ld_rsp_v with an empty queue -> err_o=1, and it stays 1 until rst_n=0.
- Hazard plus async reset: load pending to x9 with rs2_a=9 -> hazard_o=1. Asserting rst_n=0 mid-stream -> queue empty, hazard_o=0 and rd_e=0 without waiting for a clock edge.

Source files
------------

// File: rtl/u_wb.sv
// Purpose: register-file writeback that merges ALU results with in-order load responses and tracks pending loads.
// Latency: an event accepted in cycle N shows on rd_e/rd_a/rd_i in N+1; busy_o/hazard_o are combinational over the load queue.
// Backpressure: alu_rdy drops whenever a load response is present (loads always win); ld_issue_rdy drops when the queue is full.
//
// Ports:
//   clk, rst_n                                    clock, asynchronous active-low reset
//   alu_v/alu_rdy/alu_rd_a/alu_rd_i               ALU result handshake (held by the ALU until accepted)
//   ld_issue_v/ld_issue_rdy/_rd_a/_f3/_off        load issue into the pending-load queue
//   ld_rsp_v/ld_rsp_data                          in-order load data, no backpressure
//   rs1_a/rs2_a/hazard_o/busy_o                   load scoreboard seen by decode
//   rd_e/rd_a/rd_i                                registered regfile write port
//   err_o                                         sticky: orphan response or illegal load funct3
module u_wb #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_v,
    output logic            alu_rdy,
    input  logic [4:0]      alu_rd_a,
    input  logic [XLEN-1:0] alu_rd_i,
    input  logic            ld_issue_v,
    output logic            ld_issue_rdy,
    input  logic [4:0]      ld_issue_rd_a,
    input  logic [2:0]      ld_issue_f3,
    input  logic [1:0]      ld_issue_off,
    input  logic            ld_rsp_v,
    input  logic [XLEN-1:0] ld_rsp_data,
    input  logic [4:0]      rs1_a,
    input  logic [4:0]      rs2_a,
    output logic            hazard_o,
    output logic [31:0]     busy_o,
    output logic            rd_e,
    output logic [4:0]      rd_a,
    output logic [XLEN-1:0] rd_i,
    output logic            err_o
);
    localparam int PW = $clog2(LQ_DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    localparam cnt_t LQ_FULL = cnt_t'(LQ_DEPTH);

    typedef struct packed {
        logic [4:0] rd_a;
        logic [2:0] f3;
        logic [1:0] off;
    } lq_ent_t;

    lq_ent_t             lq [LQ_DEPTH];
    ptr_t                wr_ptr;
    ptr_t                rd_ptr;
    cnt_t                count;
    lq_ent_t             head;
    logic                lq_push;
    logic                lq_pop;
    logic                rsp_orphan;
    logic                alu_acc;
    logic [LQ_DEPTH-1:0] ent_vld;
    logic [31:0]         busy_c;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Memory returns the aligned word; pick the addressed byte/half and extend.
    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                                 input logic [1:0] off,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            3'b010:  r = w;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Readiness looks at count only, so a same-cycle pop never makes room for a push.
    assign ld_issue_rdy = (count < LQ_FULL);
    assign alu_rdy      = ~ld_rsp_v;

    assign head       = lq[rd_ptr];
    assign lq_push    = ld_issue_v & ld_issue_rdy;
    assign lq_pop     = ld_rsp_v & (count != '0);
    assign rsp_orphan = ld_rsp_v & (count == '0);
    assign alu_acc    = alu_v & alu_rdy;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        ptr_t rel;
        rel     = '0;
        ent_vld = '0;
        busy_c  = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            rel        = ptr_t'(i) - rd_ptr;
            ent_vld[i] = ({1'b0, rel} < count);
            if (ent_vld[i]) begin
                busy_c[lq[i].rd_a] = 1'b1;
            end
        end
        busy_c[0] = 1'b0;
    end

    assign busy_o   = busy_c;
    assign hazard_o = busy_c[rs1_a] | busy_c[rs2_a];

    // Queue storage needs no reset: liveness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (lq_push) begin
            lq[wr_ptr] <= '{rd_a: ld_issue_rd_a, f3: ld_issue_f3, off: ld_issue_off};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_e   <= 1'b0;
            rd_a   <= '0;
            rd_i   <= '0;
            err_o  <= 1'b0;
        end else begin
            rd_e <= 1'b0;
            if (lq_pop) begin
                rd_e <= (head.rd_a != 5'd0);
                rd_a <= head.rd_a;
                rd_i <= fmt_load(head.f3, head.off, ld_rsp_data);
            end else if (alu_acc) begin
                rd_e <= (alu_rd_a != 5'd0);
                rd_a <= alu_rd_a;
                rd_i <= alu_rd_i;
            end
            if (rsp_orphan || (lq_pop && !f3_legal(head.f3))) begin
                err_o <= 1'b1;
            end
            if (lq_push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (lq_pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            count <= count + cnt_t'(lq_push) - cnt_t'(lq_pop);
        end
    end
endmodule

// File: tb/tb_u_wb.sv
module tb_u_wb;
    localparam int XLEN     = 32;
    localparam int LQ_DEPTH = 4;

    logic            clk;
    logic            rst_n;
    logic            alu_v;
    logic            alu_rdy;
    logic [4:0]      alu_rd_a;
    logic [XLEN-1:0] alu_rd_i;
    logic            ld_issue_v;
    logic            ld_issue_rdy;
    logic [4:0]      ld_issue_rd_a;
    logic [2:0]      ld_issue_f3;
    logic [1:0]      ld_issue_off;
    logic            ld_rsp_v;
    logic [XLEN-1:0] ld_rsp_data;
    logic [4:0]      rs1_a;
    logic [4:0]      rs2_a;
    logic            hazard_o;
    logic [31:0]     busy_o;
    logic            rd_e;
    logic [4:0]      rd_a;
    logic [XLEN-1:0] rd_i;
    logic            err_o;

    u_wb #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_v(alu_v), .alu_rdy(alu_rdy), .alu_rd_a(alu_rd_a), .alu_rd_i(alu_rd_i),
        .ld_issue_v(ld_issue_v), .ld_issue_rdy(ld_issue_rdy), .ld_issue_rd_a(ld_issue_rd_a),
        .ld_issue_f3(ld_issue_f3), .ld_issue_off(ld_issue_off),
        .ld_rsp_v(ld_rsp_v), .ld_rsp_data(ld_rsp_data),
        .rs1_a(rs1_a), .rs2_a(rs2_a), .hazard_o(hazard_o), .busy_o(busy_o),
        .rd_e(rd_e), .rd_a(rd_a), .rd_i(rd_i), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wr_t;

    int   tests = 0;
    int   fails = 0;
    ld_t  mq[$];      // reference pending-load queue
    wr_t  sb[$];      // expected register writes, in order
    bit   m_err  = 1'b0;
    bit   alu_hold = 1'b0;
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] f3);
        return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    endfunction

    // Load result from plain arithmetic on the returned word.
    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        longint b;
        longint h;
        b = longint'((w >> (8 * off)) & 32'hFF);
        h = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (f3)
            3'd0:    return 32'(b >= 128 ? b - 256 : b);
            3'd4:    return 32'(b);
            3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd5:    return 32'(h);
            3'd2:    return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) if (mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    // Apply the currently driven inputs for one clock, updating the model.
    task automatic cycle();
        bit  acc_issue;
        bit  acc_alu;
        ld_t e;
        acc_issue = ld_issue_v && (mq.size() < LQ_DEPTH);
        acc_alu   = alu_v && !ld_rsp_v;
        if (ld_rsp_v) begin
            if (mq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                e = mq.pop_front();
                if (!is_legal(e.f3)) m_err = 1'b1;
                if (e.rd != 5'd0) sb.push_back('{rd: e.rd, dat: ref_fmt(e.f3, e.off, ld_rsp_data)});
            end
        end else if (acc_alu && alu_rd_a != 5'd0) begin
            sb.push_back('{rd: alu_rd_a, dat: alu_rd_i});
        end
        if (acc_issue) mq.push_back('{rd: ld_issue_rd_a, f3: ld_issue_f3, off: ld_issue_off});
        alu_hold = alu_v && !acc_alu;
        @(posedge clk);
        #1;
        chk("busy_o", busy_o, model_mask());
        chk("ld_issue_rdy", 32'(ld_issue_rdy), 32'(mq.size() < LQ_DEPTH));
        chk("err_o", 32'(err_o), 32'(m_err));
    endtask

    task automatic drive_idle();
        alu_v = 1'b0; ld_issue_v = 1'b0; ld_rsp_v = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        drive_idle();
        ld_issue_v = 1'b1; ld_issue_rd_a = rd; ld_issue_f3 = f3; ld_issue_off = off;
        cycle();
        ld_issue_v = 1'b0;
    endtask

    task automatic do_rsp(input logic [31:0] data);
        drive_idle();
        ld_rsp_v = 1'b1; ld_rsp_data = data;
        cycle();
        ld_rsp_v = 1'b0;
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic [31:0] data);
        drive_idle();
        alu_v = 1'b1; alu_rd_a = rd; alu_rd_i = data;
        cycle();
        alu_v = 1'b0;
    endtask

    // Reset asserted away from any edge; the model is flushed with it.
    task automatic do_reset();
        @(negedge clk);
        #1;
        drive_idle();
        rst_n = 1'b0;
        mq.delete();
        m_err = 1'b0;
        alu_hold = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_free(input logic [31:0] mask, input logic [4:0] avoid);
        logic [4:0] r;
        for (int t = 0; t < 8; t++) begin
            r = 5'($urandom_range(0, 31));
            if (!mask[r] && r != avoid) return r;
        end
        return 5'd0;
    endfunction

    // Monitor: every regfile write must match the next expected write.
    initial begin
        wr_t x;
        forever begin
            @(negedge clk);
            if (rd_e !== 1'b0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got rd_a=%0d rd_i=%0h expected no write at %0t",
                             rd_a, rd_i, $time);
                end else begin
                    x = sb.pop_front();
                    chk("wr_rd_a", 32'(rd_a), 32'(x.rd));
                    chk("wr_rd_i", rd_i, x.dat);
                end
            end
        end
    end

    logic [31:0] fmt_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_0000};
    logic [2:0]  fmt_f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
    logic [1:0]  fmt_off [4] = '{2'd3, 2'd3, 2'd2, 2'd0};

    initial begin
        rst_n = 1'b0;
        drive_idle();
        alu_rd_a = '0; alu_rd_i = '0; ld_issue_rd_a = '0; ld_issue_f3 = '0; ld_issue_off = '0;
        ld_rsp_data = '0; rs1_a = '0; rs2_a = '0;
        #3;
        chk("reset_rd_e", 32'(rd_e), 32'd0);
        chk("reset_rd_a", 32'(rd_a), 32'd0);
        chk("reset_rd_i", rd_i, 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_busy", busy_o, 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_issue_rdy", 32'(ld_issue_rdy), 32'd1);
        chk("post_reset_alu_rdy", 32'(alu_rdy), 32'd1);

        // ALU write on an idle queue
        do_alu(5'd5, 32'h1234);
        chk("alu_rd_e", 32'(rd_e), 32'd1);
        chk("alu_rd_a", 32'(rd_a), 32'd5);
        chk("alu_rd_i", rd_i, 32'h1234);
        cycle();
        chk("alu_rd_e_drop", 32'(rd_e), 32'd0);

        // load formatting on 0x80FF_0000
        for (int k = 0; k < 4; k++) begin
            do_issue(5'd7, fmt_f3[k], fmt_off[k]);
            do_rsp(32'h80FF_0000);
            chk($sformatf("fmt%0d_rd_e", k), 32'(rd_e), 32'd1);
            chk($sformatf("fmt%0d_rd_a", k), 32'(rd_a), 32'd7);
            chk($sformatf("fmt%0d_rd_i", k), rd_i, fmt_exp[k]);
        end

        // collision: load response beats a held ALU result
        do_issue(5'd10, 3'd2, 2'd0);
        alu_v = 1'b1; alu_rd_a = 5'd11; alu_rd_i = 32'hA5A5;
        ld_rsp_v = 1'b1; ld_rsp_data = 32'h1122_3344;
        #1;
        chk("collide_alu_rdy", 32'(alu_rdy), 32'd0);
        cycle();
        chk("collide_first_rd_a", 32'(rd_a), 32'd10);
        chk("collide_first_rd_i", rd_i, 32'h1122_3344);
        ld_rsp_v = 1'b0;
        #1;
        chk("collide_alu_rdy_back", 32'(alu_rdy), 32'd1);
        cycle();
        chk("collide_second_rd_a", 32'(rd_a), 32'd11);
        chk("collide_second_rd_i", rd_i, 32'hA5A5);
        alu_v = 1'b0;

        // queue full
        for (int k = 1; k <= 4; k++) do_issue(5'(k), 3'd2, 2'd0);
        chk("full_rdy", 32'(ld_issue_rdy), 32'd0);
        chk("full_busy", busy_o, 32'h1E);
        do_issue(5'd5, 3'd2, 2'd0);
        chk("full_reject_busy", busy_o, 32'h1E);
        do_rsp(32'hCAFE_0001);
        chk("full_pop_rd_a", 32'(rd_a), 32'd1);
        chk("full_pop_busy", busy_o, 32'h1C);
        chk("full_pop_rdy", 32'(ld_issue_rdy), 32'd1);
        for (int k = 0; k < 3; k++) do_rsp($urandom);

        // load to x0
        do_issue(5'd0, 3'd2, 2'd0);
        chk("x0_busy", busy_o, 32'd0);
        do_rsp(32'hFFFF_FFFF);
        chk("x0_rd_e", 32'(rd_e), 32'd0);
        chk("x0_popped_rdy", 32'(ld_issue_rdy), 32'd1);

        // orphan response
        do_rsp(32'h5555_5555);
        chk("orphan_rd_e", 32'(rd_e), 32'd0);
        for (int k = 0; k < 3; k++) cycle();
        chk("orphan_err_sticky", 32'(err_o), 32'd1);
        do_reset();
        chk("err_cleared", 32'(err_o), 32'd0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] m;
            m = model_mask();
            if (!alu_hold) begin
                alu_v = ($urandom_range(0, 2) != 0);
                alu_rd_a = pick_free(m, 5'd0);
                alu_rd_i = $urandom;
            end
            ld_issue_v    = ($urandom_range(0, 1) != 0);
            ld_issue_rd_a = pick_free(m, alu_v ? alu_rd_a : 5'd0);
            ld_issue_f3   = legal_f3[$urandom_range(0, 4)];
            ld_issue_off  = 2'($urandom_range(0, 3));
            ld_rsp_v      = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
            ld_rsp_data   = $urandom;
            rs1_a         = 5'($urandom_range(0, 31));
            rs2_a         = 5'($urandom_range(0, 31));
            #1;
            chk("rand_hazard", 32'(hazard_o), 32'(m[rs1_a] | m[rs2_a]));
            chk("rand_alu_rdy", 32'(alu_rdy), 32'(!ld_rsp_v));
            cycle();
        end
        drive_idle();
        alu_hold = 1'b0;
        while (mq.size() > 0) do_rsp($urandom);

        // illegal funct3
        chk("pre_badf3_err", 32'(err_o), 32'd0);
        do_issue(5'd6, 3'd3, 2'd1);
        do_rsp(32'hDEAD_BEEF);
        chk("badf3_rd_e", 32'(rd_e), 32'd1);
        chk("badf3_rd_i", rd_i, 32'd0);
        chk("badf3_err", 32'(err_o), 32'd1);
        do_reset();

        // hazard, then async reset with a load in flight
        do_issue(5'd9, 3'd2, 2'd0);
        rs1_a = 5'd0; rs2_a = 5'd9;
        #1;
        chk("hazard_set", 32'(hazard_o), 32'd1);
        do_alu(5'd3, 32'h3333);
        chk("pre_reset_rd_e", 32'(rd_e), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_hazard", 32'(hazard_o), 32'd0);
        chk("async_rd_e", 32'(rd_e), 32'd0);
        chk("async_busy", busy_o, 32'd0);
        chk("async_rdy", 32'(ld_issue_rdy), 32'd1);
        mq.delete();
        m_err = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_rsp(32'h0BAD_0BAD);
        chk("late_rsp_err", 32'(err_o), 32'd1);

        for (int k = 0; k < 3; k++) cycle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
